// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared widths and memory-responder state encoding for the CPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 16;
  localparam int RD_LAT_MAX = 15;
  localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_addr_sel.sv
// ============================================================================
// Module  : mem_addr_sel
// Purpose : Combinational bus-cycle source mux (address PC/IRL/SP, data AC/PC).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_addr_sel #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          fetch,
  input  logic          sp_addr,
  input  logic          do_jsr,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] irl,
  input  logic [AW-1:0] sp,
  input  logic [DW-1:0] ac,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata
);

  // Stack access outranks instruction fetch.
  assign addr  = sp_addr ? sp : (fetch ? pc : irl);
  assign wdata = do_jsr ? DW'(pc) : ac;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module  : mem_responder
// Purpose : Runs fixed-latency read/write cycles on a synchronous RAM for control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import cpu_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          RD_REQ,
  input  logic          WR_REQ,
  input  logic          FETCH,
  input  logic          SP_ADDR,
  input  logic          DO_JSR,
  input  logic [AW-1:0] PC,
  input  logic [AW-1:0] IRL,
  input  logic [AW-1:0] SP,
  input  logic [DW-1:0] AC,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_WE,
  output logic          MEM_RE,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [DW-1:0] RDATA,
  output logic          ACK,
  output logic          BUSY,
  output logic          ERR
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  mem_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          is_wr_q, is_wr_d;

  mem_addr_sel #(
    .AW (AW),
    .DW (DW)
  ) u_sel (
    .fetch   (FETCH),
    .sp_addr (SP_ADDR),
    .do_jsr  (DO_JSR),
    .pc      (PC),
    .irl     (IRL),
    .sp      (SP),
    .ac      (AC),
    .addr    (sel_addr),
    .wdata   (sel_wdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    is_wr_d = is_wr_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (WR_REQ || RD_REQ) begin
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          busy_d  = 1'b1;
          is_wr_d = WR_REQ;
          if (WR_REQ) begin
            state_d = WR_ISSUE;
            we_d    = 1'b1;
            err_d   = RD_REQ;
          end else begin
            state_d = RD_ISSUE;
            re_d    = 1'b1;
          end
        end
      end
      WR_ISSUE: begin
        state_d = RESP;
        ack_d   = 1'b1;
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
        cnt_d   = LAT_LOAD;
      end
      RD_WAIT: begin
        // Counter reaches zero in the cycle MEM_RDATA becomes valid.
        if (cnt_q == '0) begin
          rdata_d = MEM_RDATA;
          ack_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (!(is_wr_q ? WR_REQ : RD_REQ)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      is_wr_q <= is_wr_d;
    end
  end

  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign MEM_WE    = we_q;
  assign MEM_RE    = re_q;
  assign RDATA     = rdata_q;
  assign ACK       = ack_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;

endmodule

`default_nettype wire
